// File: rtl/riscv_lsu_pkg.sv
// rtl/riscv_lsu_pkg.sv - shared types and helpers for the MEM-stage load/store unit
package riscv_lsu_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_e;

  typedef enum logic [2:0] {IDLE, RD, LD, WR, RESP} lsu_state_e;

  function automatic logic [3:0] size_nbytes(input lsu_size_e size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// rtl/riscv_lsu_align.sv - byte lane extract/extend for loads and merge for stores
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [XLEN-1:0] i_word,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [2:0]      i_off,
  input  lsu_size_e       i_size,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_ld_data,
  output logic [XLEN-1:0] o_st_word
);

  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_wdata_sh;
  logic [3:0]      w_nbytes;

  assign w_shifted  = i_word >> {i_off, 3'b000};
  assign w_wdata_sh = i_wdata << {i_off, 3'b000};
  assign w_nbytes   = size_nbytes(i_size);

  always_comb begin
    o_ld_data = '0;
    case (i_size)
      SZ_B: o_ld_data = i_unsigned ? {56'd0, w_shifted[7:0]}  : {{56{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H: o_ld_data = i_unsigned ? {48'd0, w_shifted[15:0]} : {{48{w_shifted[15]}}, w_shifted[15:0]};
      SZ_W: o_ld_data = i_unsigned ? {32'd0, w_shifted[31:0]} : {{32{w_shifted[31]}}, w_shifted[31:0]};
      default: o_ld_data = w_shifted;
    endcase
  end

  // Only lanes inside [off, off+nbytes) take the shifted store data; the rest keep the RAM word.
  always_comb begin
    o_st_word = i_word;
    for (int i = 0; i < 8; i++) begin
      if (i >= int'(i_off) && i < int'(i_off) + int'(w_nbytes)) begin
        o_st_word[8*i +: 8] = w_wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - MEM-stage load/store unit driving a word-addressed 64-bit RAM
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DATA_DEPTH = 16384,
  parameter int MEM_AW     = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  lsu_state_e            r_state, w_next;
  logic                  r_we;
  lsu_size_e             r_size;
  logic                  r_unsigned;
  logic [2:0]            r_off;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [MEM_AW-1:0]     r_mem_addr;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_err;

  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic                  w_err;
  lsu_size_e             w_req_size;
  logic [DATA_WIDTH-1:0] w_ld_data;
  logic [DATA_WIDTH-1:0] w_st_word;

  assign w_req_size = lsu_size_e'(req_size);
  assign req_ready  = (r_state == IDLE) && !rst;
  assign w_accept   = req_valid && req_ready;

  always_comb begin
    w_misaligned = 1'b0;
    case (w_req_size)
      SZ_H:    w_misaligned = req_addr[0];
      SZ_W:    w_misaligned = |req_addr[1:0];
      SZ_D:    w_misaligned = |req_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_out_of_range = |req_addr[DATA_WIDTH-1:MEM_AW+3];
  assign w_err          = w_misaligned || w_out_of_range;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err)                              w_next = RESP;
          else if (req_we && w_req_size == SZ_D)  w_next = WR;
          else                                    w_next = RD;
        end
      end
      RD:      w_next = r_we ? WR : LD;
      LD:      w_next = RESP;
      WR:      w_next = RESP;
      RESP:    w_next = resp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_size       <= SZ_B;
      r_unsigned   <= 1'b0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_mem_addr   <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we         <= req_we;
        r_size       <= w_req_size;
        r_unsigned   <= req_unsigned;
        r_off        <= req_addr[2:0];
        r_wdata      <= req_wdata;
        r_resp_rdata <= '0;
        r_resp_err   <= w_err;
        if (!w_err) r_mem_addr <= req_addr[MEM_AW+2:3];
      end
      if (r_state == LD) r_resp_rdata <= w_ld_data;
    end
  end

  riscv_lsu_align u_align (
    .i_word     (mem_rd_data),
    .i_wdata    (r_wdata),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_ld_data  (w_ld_data),
    .o_st_word  (w_st_word)
  );

  // Write strobe and data are decoded from state so a WR cycle overlapping reset still writes once.
  assign mem_we      = (r_state == WR);
  assign mem_wr_data = (r_state == WR) ? w_st_word : '0;
  assign mem_addr    = r_mem_addr;
  assign resp_valid  = (r_state == RESP);
  assign resp_rdata  = r_resp_rdata;
  assign resp_err    = r_resp_err;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - self-checking bench for riscv_lsu with a RAM model and byte-level reference memory
module tb_riscv_lsu;

  localparam int DEPTH  = 16384;
  localparam int NBYTES = DEPTH * 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wr_data, mem_rd_data;

  logic        bd_we = 1'b0;
  logic [13:0] bd_addr = '0;
  logic [63:0] bd_data = '0;

  logic [63:0] ram [0:DEPTH-1] = '{default: 64'd0};
  logic [7:0]  ref_b [0:NBYTES-1];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  riscv_lsu #(.DATA_WIDTH(64), .DATA_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data)
  );

  always @(posedge clk) begin
    if (bd_we)       ram[bd_addr]  <= bd_data;
    else if (mem_we) ram[mem_addr] <= mem_wr_data;
    mem_rd_data <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_word(input int idx);
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_b[idx*8 + i];
    return w;
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic preload(input int idx, input logic [63:0] data);
    bd_we = 1'b1; bd_addr = 14'(idx); bd_data = data;
    @(negedge clk);
    bd_we = 1'b0;
    for (int i = 0; i < 8; i++) ref_b[idx*8 + i] = data[8*i +: 8];
  endtask

  // Reference behaviour from byte-addressed memory semantics; applies stores to ref_b.
  task automatic model(input bit we, input int sz, input bit uns, input logic [63:0] addr,
                       input logic [63:0] wd, output logic [63:0] e_rdata, output bit e_err,
                       output int e_lat, output int e_we);
    int nb = 1 << sz;
    logic [63:0] v = '0;
    e_err = ((addr % nb) != 0) || (addr >= 64'(NBYTES));
    e_rdata = '0;
    e_we = 0;
    if (e_err) begin
      e_lat = 1;
    end else if (we) begin
      for (int i = 0; i < nb; i++) ref_b[int'(addr) + i] = wd[8*i +: 8];
      e_lat = (nb == 8) ? 2 : 3;
      e_we = 1;
    end else begin
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_b[int'(addr) + i];
      if (!uns && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
      e_rdata = v;
      e_lat = 3;
    end
  endtask

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic do_req(input bit we, input int sz, input bit uns, input logic [63:0] addr,
                        input logic [63:0] wd, input int hold);
    logic [63:0] e_rdata;
    bit e_err;
    int e_lat, e_we, lat, we_cnt, we_at, n;
    model(we, sz, uns, addr, wd, e_rdata, e_err, e_lat, e_we);
    req_valid = 1'b1; req_we = we; req_size = 2'(sz); req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    lat = 1; we_cnt = 0; we_at = 0;
    while (!resp_valid && lat < 20) begin
      if (mem_we) begin we_cnt++; we_at = lat; end
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(e_lat));
    chk("resp_err", 64'(resp_err), 64'(e_err));
    chk("resp_rdata", resp_rdata, e_rdata);
    chk("we_pulses", 64'(we_cnt), 64'(e_we));
    if (e_we == 1) chk("we_cycle", 64'(we_at), 64'(e_lat - 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_rdata", resp_rdata, e_rdata);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_mem_we", 64'(mem_we), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_resp_ready", 64'(req_ready), 64'd1);
    chk("post_resp_valid", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int sz, nb, idx, off, r;
    logic [63:0] addr;
    int we_seen;
    for (int i = 0; i < NBYTES; i++) ref_b[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wr_data", mem_wr_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_req(1'b1, 3, 1'b0, 64'h100, 64'h0123456789ABCDEF, 0);
    chk("d_store_ram", ram[32], 64'h0123456789ABCDEF);
    do_req(1'b0, 3, 1'b0, 64'h100, 64'h0, 0);

    preload(32, 64'h1122334455667788);
    do_req(1'b1, 0, 1'b0, 64'h103, 64'h55555555555555AA, 0);
    chk("b_store_ram", ram[32], 64'h11223344AA667788);
    do_req(1'b0, 0, 1'b0, 64'h103, 64'h0, 0);
    do_req(1'b0, 0, 1'b1, 64'h103, 64'h0, 0);

    do_req(1'b0, 1, 1'b0, 64'h101, 64'h0, 0);
    chk("err_ram_unchanged", ram[32], 64'h11223344AA667788);
    do_req(1'b0, 2, 1'b0, 64'h2_0000, 64'h0, 0);
    do_req(1'b1, 2, 1'b0, 64'h1_FFFC, 64'hDEADBEEF_CAFEF00D, 0);
    chk("top_word_ram", ram[DEPTH-1], ref_word(DEPTH-1));

    do_req(1'b0, 2, 1'b0, 64'h104, 64'h0, 5);

    preload(64, 64'hA5A5A5A5A5A5A5A5);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 64'h204; req_wdata = 64'h0000000012345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    we_seen = 0;
    #1;
    chk("rst_mid_ready_after", 64'(req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (mem_we) we_seen++;
      @(negedge clk);
    end
    chk("rst_mid_no_write", 64'(we_seen), 64'd0);
    chk("rst_mid_ram", ram[64], 64'hA5A5A5A5A5A5A5A5);
    chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);

    for (int t = 0; t < 10000; t++) begin
      sz = int'($urandom_range(0, 3));
      nb = 1 << sz;
      idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : DEPTH - 1 - int'($urandom_range(0, 31));
      r = int'($urandom_range(0, 15));
      off = (r == 0) ? int'($urandom_range(0, 7)) : (int'($urandom_range(0, 7)) / nb) * nb;
      addr = 64'(idx) * 64'd8 + 64'(off);
      if (r == 1) addr = addr | (64'd1 << $urandom_range(17, 63));
      do_req($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1, addr,
             {$urandom, $urandom}, ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    for (int i = 0; i < 32; i++) chk("final_ram_low", ram[i], ref_word(i));
    for (int i = DEPTH - 32; i < DEPTH; i++) chk("final_ram_high", ram[i], ref_word(i));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
